// File: rtl/la_hstx.sv
// rtl/la_hstx.sv - four-phase req/ack CDC source-side controller
// Holds tx_data stable until the synchronized tx_ack has completed a full rise/fall cycle.
module la_hstx #(
   parameter PROP = "DEFAULT",
   parameter int DW = 32,
   parameter int STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          tx_req,
   output logic [DW-1:0] tx_data,
   input  logic          tx_ack,
   output logic          busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   logic [STAGES-1:0] sync_q;
   logic              ack_s;
   logic [1:0]        state_q, state_d;
   logic              req_q, req_d;
   logic [DW-1:0]     data_q, data_d;
   logic              accept;

   if (PROP == "") begin : g_prop_none
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], tx_ack};
      end
   end

   assign ack_s = sync_q[STAGES-1];

   // Gating on ~ack_s stops an accept against a stale ack left over from before reset.
   assign in_ready = (state_q == ST_IDLE) && !ack_s;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               data_d  = in_data;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               state_d = ST_REL;
               req_d   = 1'b0;
            end
         end
         ST_REL: begin
            if (!ack_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
      end
   end

   assign tx_req  = req_q;
   assign tx_data = data_q;

endmodule

// File: tb/tb_la_hstx.sv
// tb/tb_la_hstx.sv - bench for la_hstx with STAGES=2 directed cases and STAGES=3 random traffic
module tb_la_hstx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Instance a: STAGES=2
   logic        a_reset = 1'b1, a_valid = 1'b0, a_loop = 1'b0, a_ack_man = 1'b0;
   logic [31:0] a_data = '0;
   logic        a_ready, a_req, a_busy, a_ack;
   logic [31:0] a_txd;
   assign a_ack = a_loop ? a_req : a_ack_man;

   la_hstx #(.PROP("DEFAULT"), .DW(32), .STAGES(2)) dut_a (
      .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_ready), .tx_req(a_req), .tx_data(a_txd), .tx_ack(a_ack), .busy(a_busy));

   // Instance b: STAGES=3
   logic        b_reset = 1'b1, b_valid = 1'b0, b_ack = 1'b0;
   logic [31:0] b_data = '0;
   logic        b_ready, b_req, b_busy;
   logic [31:0] b_txd;

   la_hstx #(.PROP("DEFAULT"), .DW(32), .STAGES(3)) dut_b (
      .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_ready), .tx_req(b_req), .tx_data(b_txd), .tx_ack(b_ack), .busy(b_busy));

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
      $fatal(1, "watchdog");
   end

   task automatic drain_a(input string name);
      int n = 0;
      a_valid = 1'b0;
      a_loop  = 1'b1;
      while (a_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (a_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_drain: busy=%b required 0", name, a_busy);
      end
      a_loop = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      a_reset = 1'b1; a_valid = 1'b1; a_data = 32'hDEADBEEF; a_ack_man = 1'b0; a_loop = 1'b0;
      #1;
      vectors++;
      if ({a_req, a_txd, a_busy, a_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_values: req=%b txd=%h busy=%b ready=%b required 0 00000000 0 1",
                  a_req, a_txd, a_busy, a_ready);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (a_req !== 1'b0 || a_txd !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_hold: req=%b txd=%h required 0 00000000", a_req, a_txd);
      end
      a_reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (a_req !== 1'b1 || a_txd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL reset_first_accept: req=%b txd=%h required 1 deadbeef", a_req, a_txd);
      end
      drain_a("reset");
   endtask

   task automatic test_loopback;
      logic [31:0] words [2];
      int          acc [$];
      int          idx = 0;
      int          cyc = 0;
      logic [31:0] exp_word = '0;
      words[0] = 32'hA5A5_0001;
      words[1] = 32'h5A5A_0002;
      @(negedge clk);
      a_loop = 1'b1; a_valid = 1'b1; a_data = words[0];
      while (idx < 2 && cyc < 60) begin
         if (a_ready) begin
            acc.push_back(cyc);
            idx++;
            @(negedge clk);
            cyc++;
            exp_word = words[idx-1];
            vectors++;
            if (a_req !== 1'b1 || a_txd !== exp_word) begin
               miscompares++;
               $display("FAIL loop_launch%0d: req=%b txd=%h required 1 %h", idx, a_req, a_txd, exp_word);
            end
            a_valid = (idx < 2);
            a_data  = (idx < 2) ? words[1] : 32'h0;
            continue;
         end
         @(negedge clk);
         cyc++;
         if (idx >= 1) begin
            vectors++;
            if (a_txd !== exp_word) begin
               miscompares++;
               $display("FAIL loop_stable: txd=%h required %h (req=%b)", a_txd, exp_word, a_req);
            end
         end
      end
      vectors++;
      if (acc.size() != 2) begin
         miscompares++;
         $display("FAIL loop_accepts: count=%0d required 2", acc.size());
      end else begin
         vectors++;
         if (acc[1] - acc[0] != 7) begin
            miscompares++;
            $display("FAIL loop_spacing: cycles=%0d required 7", acc[1] - acc[0]);
         end
      end
      drain_a("loop");
   endtask

   task automatic test_slow_far_side;
      int          n;
      logic [31:0] w = $urandom;
      @(negedge clk);
      a_loop = 1'b0; a_ack_man = 1'b0; a_valid = 1'b1; a_data = w;
      @(negedge clk);
      a_valid = 1'b0;
      vectors++;
      if (a_req !== 1'b1 || a_txd !== w) begin
         miscompares++;
         $display("FAIL slow_launch: req=%b txd=%h required 1 %h", a_req, a_txd, w);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vectors++;
         if ({a_req, a_ready, a_busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL slow_wait_rise: req/ready/busy=%b required 101", {a_req, a_ready, a_busy});
         end
      end
      a_ack_man = 1'b1;
      n = 0;
      while (a_req && n < 10) begin
         @(negedge clk);
         n++;
         vectors++;
         if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL slow_rise_flags: ready=%b busy=%b required 0 1", a_ready, a_busy);
         end
      end
      vectors++;
      if (n < 2 || n > 3) begin
         miscompares++;
         $display("FAIL slow_req_fall: edges=%0d required 2..3", n);
      end
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         vectors++;
         if ({a_req, a_ready, a_busy} !== 3'b001 || a_txd !== w) begin
            miscompares++;
            $display("FAIL slow_rel: req/ready/busy=%b txd=%h required 001 %h",
                     {a_req, a_ready, a_busy}, a_txd, w);
         end
      end
      a_ack_man = 1'b0;
      n = 0;
      while (a_busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n < 2 || n > 3 || a_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL slow_idle: edges=%0d ready=%b required 2..3 1", n, a_ready);
      end
   endtask

   task automatic test_stale_ack;
      int          n;
      logic [31:0] w = $urandom;
      @(negedge clk);
      a_loop = 1'b0; a_valid = 1'b0; a_ack_man = 1'b1; a_reset = 1'b1;
      @(negedge clk);
      a_reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (a_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stale_ready_drop: ready=%b required 0", a_ready);
      end
      a_valid = 1'b1; a_data = w;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (a_ready !== 1'b0 || a_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_no_accept: ready=%b req=%b required 0 0", a_ready, a_req);
         end
      end
      a_ack_man = 1'b0;
      n = 0;
      while (!a_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n + 1 < 2 || n + 1 > 3) begin
         miscompares++;
         $display("FAIL stale_accept_edge: edge=%0d required 2..3", n + 1);
      end
      @(negedge clk);
      vectors++;
      if (a_req !== 1'b1 || a_txd !== w) begin
         miscompares++;
         $display("FAIL stale_launch: req=%b txd=%h required 1 %h", a_req, a_txd, w);
      end
      drain_a("stale");
   endtask

   task automatic test_mid_reset;
      logic [31:0] w1 = $urandom;
      logic [31:0] w2 = $urandom;
      @(negedge clk);
      a_loop = 1'b0; a_ack_man = 1'b0; a_valid = 1'b1; a_data = w1;
      @(negedge clk);
      a_valid = 1'b0;
      vectors++;
      if (a_req !== 1'b1 || a_txd !== w1) begin
         miscompares++;
         $display("FAIL mid_launch: req=%b txd=%h required 1 %h", a_req, a_txd, w1);
      end
      repeat (2) @(negedge clk);
      a_reset = 1'b1;
      #1;
      vectors++;
      if (a_req !== 1'b0 || a_txd !== 32'h0 || a_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_abandon: req=%b txd=%h busy=%b required 0 00000000 0", a_req, a_txd, a_busy);
      end
      @(negedge clk);
      a_reset = 1'b0; a_valid = 1'b1; a_data = w2;
      @(negedge clk);
      vectors++;
      if (a_req !== 1'b1 || a_txd !== w2) begin
         miscompares++;
         $display("FAIL mid_reaccept: req=%b txd=%h required 1 %h", a_req, a_txd, w2);
      end
      drain_a("mid");
   endtask

   task automatic test_random;
      logic [31:0] exp_q [$];
      logic        hist  [$];
      logic [31:0] launched = '0;
      logic        prev_req = 1'b0;
      logic        ack_s_m;
      int words = 0, rises = 0, cyc = 0, fs_cnt = 0;
      int fs_lat = $urandom_range(1, 30);
      repeat (3) hist.push_back(1'b0);
      @(negedge clk);
      b_ack = 1'b0; b_valid = 1'b0; b_reset = 1'b0;
      while ((words < 1000 || b_busy || b_ack) && cyc < 80000) begin
         ack_s_m = hist[2];
         vectors++;
         if (b_ready !== (!b_busy && !ack_s_m)) begin
            miscompares++;
            $display("FAIL rnd_ready cyc%0d: ready=%b required %b", cyc, b_ready, !b_busy && !ack_s_m);
         end
         if (b_req && !prev_req) begin
            rises++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rnd_extra_req cyc%0d: txd=%h required no transfer", cyc, b_txd);
            end else begin
               launched = exp_q.pop_front();
               if (b_txd !== launched) begin
                  miscompares++;
                  $display("FAIL rnd_order cyc%0d: txd=%h required %h", cyc, b_txd, launched);
               end
            end
         end
         if (b_busy) begin
            vectors++;
            if (b_txd !== launched) begin
               miscompares++;
               $display("FAIL rnd_stable cyc%0d: txd=%h required %h", cyc, b_txd, launched);
            end
         end
         prev_req = b_req;
         b_valid = (words < 1000) && ($urandom_range(0, 3) != 0);
         b_data  = $urandom;
         if (b_valid && b_ready) begin
            exp_q.push_back(b_data);
            words++;
         end
         if ((!b_ack && b_req) || (b_ack && !b_req)) begin
            fs_cnt++;
            if (fs_cnt >= fs_lat) begin
               b_ack  = ~b_ack;
               fs_cnt = 0;
               fs_lat = $urandom_range(1, 30);
            end
         end
         hist.push_front(b_ack);
         void'(hist.pop_back());
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (words != 1000 || rises != 1000 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL rnd_totals: words=%0d rises=%0d pending=%0d required 1000 1000 0",
                  words, rises, exp_q.size());
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      a_reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_loopback();
      test_slow_far_side();
      test_stale_ack();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
